// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified-RAM arbiter.
// State codes, owner codes, counter width and the grant helper.
package mem_arbiter_pkg;

    localparam int CW = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    // MEM wins unless IF is also waiting and has been starved too long.
    function automatic logic pick_owner(
        input logic if_req,
        input logic mem_req,
        input logic starved
    );
        if (mem_req && !(if_req && starved))
            return OWN_MEM;
        return OWN_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// 4-bit counter: loadable down-counter (done at 1) or saturating
// up-counter (done at MAX), chosen by SAT_UP. Ports: clk, rst, clr,
// load/load_val, step, count, done.
module mem_arbiter_lat_counter
    import mem_arbiter_pkg::*;
#(
    parameter bit            SAT_UP = 1'b0,
    parameter logic [CW-1:0] MAX    = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (step) begin
            if (SAT_UP) begin
                if (count != MAX)
                    count <= count + 1'b1;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = SAT_UP ? (count == MAX) : (count == CW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between IF (fetch) and MEM (load/store).
// Ports: clk/rst, if_* and mem_* request/ack sides, ram_* RAM side,
// stall_if/stall_mem. `MEM_ARB_STATS_EN adds if_grants/mem_grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ack,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]   if_grants,
    output logic [31:0]   mem_grants,
`endif
    output logic          stall_if,
    output logic          stall_mem
);

    logic [1:0]    state;
    logic          owner;
    logic          grant;
    logic          win;
    logic          lat_done;
    logic          starved;
    logic [CW-1:0] lat_cnt;
    logic [CW-1:0] starve_cnt;

    always_comb begin
        grant = (state == ST_IDLE) && (if_req || mem_req);
        win   = pick_owner(if_req, mem_req, starved);
    end

    // ram_we is still valid in ACCESS, so it tells load from store.
    mem_arbiter_lat_counter #(
        .SAT_UP (1'b0)
    ) u_lat (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     ((state == ST_ACCESS) && !ram_we),
        .load_val (CW'(LATENCY)),
        .step     (state == ST_WAIT),
        .count    (lat_cnt),
        .done     (lat_done)
    );

    mem_arbiter_lat_counter #(
        .SAT_UP (1'b1),
        .MAX    (CW'(STARVE_MAX))
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr      (grant && (win == OWN_IF)),
        .load     (1'b0),
        .load_val ('0),
        .step     (grant && (win == OWN_MEM) && if_req),
        .count    (starve_cnt),
        .done     (starved)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state  <= ST_ACCESS;
                        owner  <= win;
                        ram_en <= 1'b1;
                        if (win == OWN_MEM) begin
                            ram_we    <= mem_we;
                            ram_addr  <= mem_addr;
                            ram_wdata <= mem_wdata;
                        end else begin
                            ram_we   <= 1'b0;
                            ram_addr <= if_addr;
                        end
                    end
                end
                ST_ACCESS: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (ram_we) begin
                        state   <= ST_RESP;
                        mem_ack <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_done) begin
                        state <= ST_RESP;
                        if (owner == OWN_IF) begin
                            if_rdata <= ram_rdata;
                            if_ack   <= 1'b1;
                        end else begin
                            mem_rdata <= ram_rdata;
                            mem_ack   <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    if_ack  <= 1'b0;
                    mem_ack <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_grants  <= '0;
            mem_grants <= '0;
        end else if (state == ST_RESP) begin
            if (owner == OWN_IF) begin
                if (if_grants != '1)
                    if_grants <= if_grants + 1'b1;
            end else if (mem_grants != '1) begin
                mem_grants <= mem_grants + 1'b1;
            end
        end
    end
`endif

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance at LATENCY=2 plus
// LATENCY=1 and LATENCY=15 instances for the latency sweep.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ack, mem_ack, ram_en, ram_we, stall_if, stall_mem;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] if_grants, mem_grants;
    logic [31:0] a_ig, a_mg, b_ig, b_mg;
`endif

    logic        a_req, b_req, z1;
    logic [31:0] sw_addr, z32;
    logic [31:0] a_ird, a_mrd, a_ra, a_rwd, a_rrd;
    logic [31:0] b_ird, b_mrd, b_ra, b_rwd, b_rrd;
    logic        a_iack, a_mack, a_en, a_we, a_sif, a_smem;
    logic        b_iack, b_mack, b_en, b_we, b_sif, b_smem;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(2), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
`ifdef MEM_ARB_STATS_EN
        .if_grants(if_grants), .mem_grants(mem_grants),
`endif
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_arbiter #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .if_req(a_req), .if_addr(sw_addr),
        .if_rdata(a_ird), .if_ack(a_iack),
        .mem_req(z1), .mem_we(z1), .mem_addr(z32),
        .mem_wdata(z32), .mem_rdata(a_mrd), .mem_ack(a_mack),
        .ram_en(a_en), .ram_we(a_we), .ram_addr(a_ra),
        .ram_wdata(a_rwd), .ram_rdata(a_rrd),
`ifdef MEM_ARB_STATS_EN
        .if_grants(a_ig), .mem_grants(a_mg),
`endif
        .stall_if(a_sif), .stall_mem(a_smem)
    );

    mem_arbiter #(.LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst),
        .if_req(b_req), .if_addr(sw_addr),
        .if_rdata(b_ird), .if_ack(b_iack),
        .mem_req(z1), .mem_we(z1), .mem_addr(z32),
        .mem_wdata(z32), .mem_rdata(b_mrd), .mem_ack(b_mack),
        .ram_en(b_en), .ram_we(b_we), .ram_addr(b_ra),
        .ram_wdata(b_rwd), .ram_rdata(b_rrd),
`ifdef MEM_ARB_STATS_EN
        .if_grants(b_ig), .mem_grants(b_mg),
`endif
        .stall_if(b_sif), .stall_mem(b_smem)
    );

    // RAM models: read data valid only exactly LATENCY cycles after ram_en.
    logic [31:0] ram [0:255];
    logic [7:0]  raddr;
    logic [4:0]  rcnt, rca, rcb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt    <= 5'd0;
            ram[16] <= 32'hDEADBEEF;
        end else if (ram_en && ram_we) begin
            ram[ram_addr[9:2]] <= ram_wdata;
        end else if (ram_en) begin
            raddr <= ram_addr[9:2];
            rcnt  <= 5'd1;
        end else if (rcnt != 5'd0 && rcnt != 5'd31) begin
            rcnt <= rcnt + 5'd1;
        end
    end
    assign ram_rdata = (rcnt == 5'd2) ? ram[raddr] : 32'hBAD0BAD0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rca <= 5'd0;
            rcb <= 5'd0;
        end else begin
            if (a_en) rca <= 5'd1;
            else if (rca != 5'd0 && rca != 5'd31) rca <= rca + 5'd1;
            if (b_en) rcb <= 5'd1;
            else if (rcb != 5'd0 && rcb != 5'd31) rcb <= rcb + 5'd1;
        end
    end
    assign a_rrd = (rca == 5'd1)  ? 32'hA0A00001 : 32'hBAD0BAD0;
    assign b_rrd = (rcb == 5'd15) ? 32'hB0B0000F : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_if(input logic [31:0] a);
        bit got = 0;
        if_req  = 1'b1;
        if_addr = a;
        for (int k = 0; k < 40 && !got; k++) begin
            nxt();
            got = if_ack;
        end
        chk("rd_if_ack", {31'd0, got}, 32'd1);
        if_req = 1'b0;
        nxt();
    endtask

    task automatic st_mem(input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        for (int k = 0; k < 40 && !got; k++) begin
            nxt();
            got = mem_ack;
        end
        chk("st_mem_ack", {31'd0, got}, 32'd1);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        nxt();
    endtask

    initial begin
        logic [31:0] ord [5];
        int nen, macks, memb, ka, kb, ena, enb, nack;
        bit done;

        rst = 1'b1;
        if_req = 0; mem_req = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        a_req = 0; b_req = 0; z1 = 0; z32 = 0; sw_addr = 0;
        nxt();
        nxt();
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
        chk("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        rst = 1'b0;

        // Single IF read of 0x40, LATENCY=2.
        nxt();
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        chk("rd_T_stall", {31'd0, stall_if}, 32'd1);
        chk("rd_T_en", {31'd0, ram_en}, 32'd0);
        nxt();
        chk("rd_T1_en", {31'd0, ram_en}, 32'd1);
        chk("rd_T1_we", {31'd0, ram_we}, 32'd0);
        chk("rd_T1_addr", ram_addr, 32'h40);
        nxt();
        chk("rd_T2_en", {31'd0, ram_en}, 32'd0);
        chk("rd_T2_ack", {31'd0, if_ack}, 32'd0);
        nxt();
        chk("rd_T3_ack", {31'd0, if_ack}, 32'd0);
        chk("rd_T3_stall", {31'd0, stall_if}, 32'd1);
        nxt();
        chk("rd_T4_ack", {31'd0, if_ack}, 32'd1);
        chk("rd_T4_data", if_rdata, 32'hDEADBEEF);
        chk("rd_T4_stall", {31'd0, stall_if}, 32'd0);
        if_req = 1'b0;
        nxt();
        chk("rd_T5_ack", {31'd0, if_ack}, 32'd0);
        chk("rd_T5_hold", if_rdata, 32'hDEADBEEF);

        // MEM store 0x12345678 to 0x80, then IF read it back.
        mem_req = 1'b1; mem_we = 1'b1;
        mem_addr = 32'h80; mem_wdata = 32'h12345678;
        #1;
        chk("st_T_stall", {31'd0, stall_mem}, 32'd1);
        nxt();
        chk("st_T1_en", {31'd0, ram_en}, 32'd1);
        chk("st_T1_we", {31'd0, ram_we}, 32'd1);
        chk("st_T1_addr", ram_addr, 32'h80);
        chk("st_T1_wdata", ram_wdata, 32'h12345678);
        nxt();
        chk("st_T2_ack", {31'd0, mem_ack}, 32'd1);
        chk("st_T2_stall", {31'd0, stall_mem}, 32'd0);
        chk("st_T2_rdata", mem_rdata, 32'd0);
        mem_req = 1'b0; mem_we = 1'b0;
        nxt();
        if_req = 1'b1; if_addr = 32'h80;
        repeat (4) nxt();
        chk("rb_ack", {31'd0, if_ack}, 32'd1);
        chk("rb_data", if_rdata, 32'h12345678);
        if_req = 1'b0;
        nxt();

        // Both requesting continuously: MEM x3, IF, MEM.
        if_req = 1'b1; if_addr = 32'h80;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
        nen = 0; macks = 0; memb = -1; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            nxt();
            if (ram_en) begin
                if (nen < 5) ord[nen] = ram_addr;
                nen++;
            end
            if (mem_ack) begin
                macks++;
                if (nen >= 5) mem_req = 1'b0;
            end
            if (if_ack) begin
                memb = macks;
                chk("sv_if_data", if_rdata, 32'h12345678);
                if_req = 1'b0;
            end
            done = (nen >= 5) && !mem_req;
        end
        chk("sv_done", {31'd0, done}, 32'd1);
        chk("sv_g0", ord[0], 32'h40);
        chk("sv_g1", ord[1], 32'h40);
        chk("sv_g2", ord[2], 32'h40);
        chk("sv_g3", ord[3], 32'h80);
        chk("sv_g4", ord[4], 32'h40);
        chk("sv_mem_before_if", memb, 32'd3);
        chk("sv_mem_acks", macks, 32'd4);
        chk("sv_mem_data", mem_rdata, 32'hDEADBEEF);
        nxt();

        // Reset asserted during WAIT aborts the read.
        if_req = 1'b1; if_addr = 32'h40;
        nxt();
        chk("ab_en", {31'd0, ram_en}, 32'd1);
        nxt();
        rst = 1'b1;
        #1;
        chk("ab_en_rst", {31'd0, ram_en}, 32'd0);
        chk("ab_ack_rst", {31'd0, if_ack}, 32'd0);
        chk("ab_addr_rst", ram_addr, 32'd0);
        if_req = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
        nack = 0;
        for (int c = 0; c < 8; c++) begin
            nxt();
            if (if_ack) nack++;
        end
        chk("ab_no_ack", nack, 32'd0);
        if_req = 1'b1; if_addr = 32'h40;
        repeat (4) nxt();
        chk("ab_reissue_ack", {31'd0, if_ack}, 32'd1);
        chk("ab_reissue_data", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        nxt();

`ifdef MEM_ARB_STATS_EN
        rd_if(32'h40);
        rd_if(32'h40);
        rd_if(32'h80);
        rd_if(32'h40);
        st_mem(32'h84, 32'h1);
        st_mem(32'h88, 32'h2);
        chk("stat_if", if_grants, 32'd5);
        chk("stat_mem", mem_grants, 32'd2);
        rst = 1'b1;
        #1;
        chk("stat_if_rst", if_grants, 32'd0);
        chk("stat_mem_rst", mem_grants, 32'd0);
        nxt();
        rst = 1'b0;
        nxt();
`endif

        // Latency sweep: LATENCY=1 acks at T+3, LATENCY=15 at T+17.
        sw_addr = 32'h100;
        a_req = 1'b1; b_req = 1'b1;
        ka = -1; kb = -1; ena = 0; enb = 0;
        for (int k = 1; k <= 25; k++) begin
            nxt();
            if (a_en) ena++;
            if (b_en) enb++;
            if (a_iack && ka < 0) begin
                ka = k;
                chk("sw1_data", a_ird, 32'hA0A00001);
                a_req = 1'b0;
            end
            if (b_iack && kb < 0) begin
                kb = k;
                chk("sw15_data", b_ird, 32'hB0B0000F);
                b_req = 1'b0;
            end
        end
        chk("sw1_ack_cycle", ka, 32'd3);
        chk("sw15_ack_cycle", kb, 32'd17);
        chk("sw1_en_pulses", ena, 32'd1);
        chk("sw15_en_pulses", enb, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port unified RAM between the pipeline's IF stage (instruction fetch, read-only) and MEM stage (load/store). Sequences each RAM access through a fixed-latency handshake and returns read data with a one-cycle ack. Produces stall signals the pipeline uses to freeze while a requester waits. MEM has priority; an anti-starvation counter guarantees IF progress.

Parameters:
AW, 32, address width
DW, 32, data width
LATENCY, 2, RAM read latency in cycles after ram_en; legal 1..15
STARVE_MAX, 3, consecutive MEM wins over a pending IF before IF is forced; legal 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  IF read request; held with if_addr stable until if_ack
if_addr  in  AW  IF byte address
if_rdata  out  DW  IF read data, valid while if_ack=1
if_ack  out  1  one-cycle completion pulse
mem_req  in  1  MEM request; held with mem_we/addr/wdata stable until mem_ack
mem_we  in  1  1=store, 0=load
mem_addr  in  AW  MEM byte address
mem_wdata  in  DW  store data
mem_rdata  out  DW  load data, valid while mem_ack=1
mem_ack  out  1  one-cycle completion pulse
ram_en  out  1  RAM access strobe, exactly one cycle per transaction
ram_we  out  1  RAM write enable, qualified by ram_en
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, valid LATENCY cycles after the ram_en cycle
stall_if  out  1  if_req & ~if_ack (combinational)
stall_mem  out  1  mem_req & ~mem_ack (combinational)

Behaviour:
- Reset (async, immediate): state IDLE; ram_en, ram_we, if_ack, mem_ack = 0; ram_addr, ram_wdata, if_rdata, mem_rdata = 0; starve and latency counters = 0.
- States: IDLE -> ACCESS -> WAIT (reads only) -> RESP -> IDLE. All ram_* and ack outputs registered.
- IDLE: arbitrate on sampled requests. Only mem_req -> MEM; only if_req -> IF; both -> MEM unless starve==STARVE_MAX, then IF. None -> stay IDLE. Winner latched as owner.
- ACCESS (1 cycle): ram_en=1, ram_addr/ram_we/ram_wdata from owner (ram_we=0 for IF). Store -> RESP; load/fetch -> WAIT with latency counter loaded to LATENCY.
- WAIT: counter decrements each cycle; on the cycle it reaches 1, capture ram_rdata into owner's rdata register at that edge and go to RESP. WAIT lasts exactly LATENCY cycles.
- RESP (1 cycle): owner's ack=1; rdata held (store: mem_rdata unchanged). Always returns to IDLE, so a still-high req in the ack cycle is not re-granted; requester deasserts or presents a new request from the next cycle.
- Timing: req seen in IDLE at cycle T -> ram_en at T+1 -> ack at T+2+LATENCY (read) or T+2 (store).
- Starve counter: +1 (saturating at STARVE_MAX) when MEM granted while if_req=1; cleared when IF granted; unchanged otherwise.
- Requests changing while not owner are ignored until next IDLE; owner dropping req mid-transaction is a protocol error; transaction still completes and acks.
- Reset mid-transaction aborts immediately; no ack issued; requester re-issues after reset.

Optional Feature:
MEM_ARB_STATS_EN: when defined, adds outputs if_grants and mem_grants (32-bit each, saturating at all-ones, cleared by rst), incremented on each respective RESP cycle. When undefined, ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared header mem_arb_defs.vh: state encodings (IDLE=0, ACCESS=1, WAIT=2, RESP=3), owner codes (OWN_IF=0, OWN_MEM=1), counter width 4.
- One sub-module: lat_counter (loadable 4-bit down-counter with done flag), instantiated twice: latency and starve (starve uses saturating-up mode selected by parameter).

Test Plan:
- Single IF read, LATENCY=2, RAM[0x40]=0xDEADBEEF: if_req at T -> ram_en=1 at T+1, if_ack=1 with if_rdata=0xDEADBEEF at T+4, stall_if high T..T+3.
- MEM store addr 0x80 data 0x12345678 -> ram_en=ram_we=1 at T+1, mem_ack at T+2, later IF read of 0x80 returns 0x12345678.
- Simultaneous if_req/mem_req held continuously, STARVE_MAX=3 -> grant order MEM, MEM, MEM, IF, MEM...; IF ack occurs after exactly three MEM acks.
- LATENCY=1 vs 15 sweep: read ack at T+3 and T+17 respectively; ram_en exactly one cycle each.
- rst asserted during WAIT: ram_en/acks drop immediately, state IDLE, no ack after release; re-issued request completes normally.
- MEM_ARB_STATS_EN defined: 5 IF + 2 MEM transactions -> if_grants=5, mem_grants=2; rst clears both to 0.
